// File: rtl/spi_pin_conditioner.sv
// SPI pin front end: 2-FF synchronizers, persistence glitch filters,
// clean levels, edge strobes and cs-qualified sclk strobes.
module spi_pin_conditioner #(
  parameter int WAIT_TIME = 10,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic sclk_cond,
  output logic sclk_pe,
  output logic sclk_ne,
  output logic sclk_pe_act,
  output logic sclk_ne_act,
  output logic cs_cond,
  output logic frame_start,
  output logic frame_end,
  output logic mosi_cond
);

  // channel order: bit 0 sclk, bit 1 cs, bit 2 mosi
  localparam int NCH = 3;
  localparam logic [NCH-1:0] IDLE = 3'b010;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_TIME);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   cond;
  logic [NCH-1:0]   pe;
  logic [NCH-1:0]   ne;
  logic [CNT_W-1:0] cnt [NCH];

  assign raw = {mosi_pin, cs_pin, sclk_pin};

  // two-flop synchronizer, reset to idle pin levels
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // persistence filter: a mismatch must survive WAIT_TIME+1 cycles
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        cond[i] <= IDLE[i];
        cnt[i]  <= '0;
        pe[i]   <= 1'b0;
        ne[i]   <= 1'b0;
      end else if (sync2[i] == cond[i]) begin
        cnt[i] <= '0;
        pe[i]  <= 1'b0;
        ne[i]  <= 1'b0;
      end else if (cnt[i] < LIMIT) begin
        cnt[i] <= cnt[i] + 1'b1;
        pe[i]  <= 1'b0;
        ne[i]  <= 1'b0;
      end else begin
        cond[i] <= sync2[i];
        cnt[i]  <= '0;
        pe[i]   <= sync2[i];
        ne[i]   <= ~sync2[i];
      end
    end
  end

  assign sclk_cond   = cond[0];
  assign sclk_pe     = pe[0];
  assign sclk_ne     = ne[0];
  assign cs_cond     = cond[1];
  assign frame_start = ne[1];
  assign frame_end   = pe[1];
  assign mosi_cond   = cond[2];

  // sclk strobes count only while the frame (cs low) is open
  assign sclk_pe_act = pe[0] & ~cond[1];
  assign sclk_ne_act = ne[0] & ~cond[1];

endmodule

// File: tb/tb_spi_pin_conditioner.sv
// Bench for spi_pin_conditioner: window-based reference model
// checked every cycle, plus directed literal checks.
module tb_spi_pin_conditioner;

  localparam int W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk_pin = 1'b0;
  logic cs_pin = 1'b1;
  logic mosi_pin = 1'b0;
  logic sclk_cond, sclk_pe, sclk_ne, sclk_pe_act, sclk_ne_act;
  logic cs_cond, frame_start, frame_end, mosi_cond;

  int checks = 0;
  int errors = 0;

  spi_pin_conditioner #(.WAIT_TIME(W), .CNT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .sclk_pin(sclk_pin),
    .cs_pin(cs_pin),
    .mosi_pin(mosi_pin),
    .sclk_cond(sclk_cond),
    .sclk_pe(sclk_pe),
    .sclk_ne(sclk_ne),
    .sclk_pe_act(sclk_pe_act),
    .sclk_ne_act(sclk_ne_act),
    .cs_cond(cs_cond),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .mosi_cond(mosi_cond)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model. Each pin reaches the filter two samples late.
  // A level is accepted when the last W+1 filter samples all
  // disagree with the current level.
  bit idle [3] = '{1'b0, 1'b1, 1'b0};
  bit dly  [3][2];
  bit hist [3][W+1];
  int hv   [3];
  bit mc   [3];
  bit mpe  [3];
  bit mne  [3];
  bit armed = 1'b0;

  task automatic model_step(input bit rs, input bit pv [3]);
    for (int c = 0; c < 3; c++) begin
      if (rs) begin
        dly[c][0] = idle[c];
        dly[c][1] = idle[c];
        hv[c] = 0;
        mc[c] = idle[c];
        mpe[c] = 1'b0;
        mne[c] = 1'b0;
      end else begin
        bit s;
        bit all_diff;
        s = dly[c][1];
        for (int k = 0; k < W; k++) hist[c][k] = hist[c][k+1];
        hist[c][W] = s;
        if (hv[c] < W + 1) hv[c]++;
        all_diff = (hv[c] == W + 1);
        for (int k = 0; k <= W; k++)
          if (hist[c][k] == mc[c]) all_diff = 1'b0;
        mpe[c] = 1'b0;
        mne[c] = 1'b0;
        if (all_diff) begin
          mc[c] = s;
          mpe[c] = s;
          mne[c] = ~s;
        end
        dly[c][1] = dly[c][0];
        dly[c][0] = pv[c];
      end
    end
  endtask

  int n_fs, n_fe, n_pe, n_ne, n_pea, n_nea, n_mosi_hi;

  // model update on each edge, compare just after it
  always @(posedge clk) begin
    bit rs;
    bit pv [3];
    rs = reset;
    pv[0] = sclk_pin;
    pv[1] = cs_pin;
    pv[2] = mosi_pin;
    model_step(rs, pv);
    if (rs) armed = 1'b1;
    #1;
    if (armed) begin
      chk("sclk_cond", sclk_cond, mc[0]);
      chk("sclk_pe", sclk_pe, mpe[0]);
      chk("sclk_ne", sclk_ne, mne[0]);
      chk("sclk_pe_act", sclk_pe_act, mpe[0] & ~mc[1]);
      chk("sclk_ne_act", sclk_ne_act, mne[0] & ~mc[1]);
      chk("cs_cond", cs_cond, mc[1]);
      chk("frame_start", frame_start, mne[1]);
      chk("frame_end", frame_end, mpe[1]);
      chk("mosi_cond", mosi_cond, mc[2]);
      n_fs += int'(frame_start);
      n_fe += int'(frame_end);
      n_pe += int'(sclk_pe);
      n_ne += int'(sclk_ne);
      n_pea += int'(sclk_pe_act);
      n_nea += int'(sclk_ne_act);
      n_mosi_hi += int'(mosi_cond);
    end
  end

  task automatic clr_counts();
    n_fs = 0; n_fe = 0; n_pe = 0; n_ne = 0;
    n_pea = 0; n_nea = 0; n_mosi_hi = 0;
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_periods(input int n);
    for (int p = 0; p < n; p++) begin
      sclk_pin = 1'b1;
      negs(8);
      sclk_pin = 1'b0;
      negs(8);
    end
  endtask

  int hold [3];

  initial begin
    clr_counts();
    // 1: reset and idle
    reset = 1'b1;
    negs(2);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      chk("idle_cs", cs_cond, 1'b1);
      chk("idle_sclk", sclk_cond, 1'b0);
      chk("idle_mosi", mosi_cond, 1'b0);
    end
    chk_int("idle_pulses", n_fs + n_fe + n_pe + n_ne, 0);

    // 2: sclk rise latency, update at edge k+5
    @(negedge clk);
    sclk_pin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("lat_early", sclk_cond, 1'b0);
      chk("lat_early_pe", sclk_pe, 1'b0);
    end
    @(posedge clk); #2;
    chk("lat_cond", sclk_cond, 1'b1);
    chk("lat_pe", sclk_pe, 1'b1);
    @(posedge clk); #2;
    chk("lat_pe_drop", sclk_pe, 1'b0);
    @(negedge clk);
    sclk_pin = 1'b0;
    negs(10);

    // 3: mosi glitch rejected, then accepted
    clr_counts();
    mosi_pin = 1'b1;
    negs(3);
    mosi_pin = 1'b0;
    negs(12);
    chk_int("glitch_mosi", n_mosi_hi, 0);
    mosi_pin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("mosi_early", mosi_cond, 1'b0);
    end
    @(posedge clk); #2;
    chk("mosi_6th", mosi_cond, 1'b1);
    @(negedge clk);
    mosi_pin = 1'b0;
    negs(10);

    // 4: framed transfer
    clr_counts();
    cs_pin = 1'b0;
    negs(12);
    sclk_periods(4);
    negs(4);
    cs_pin = 1'b1;
    negs(12);
    chk_int("frm_start", n_fs, 1);
    chk_int("frm_end", n_fe, 1);
    chk_int("frm_pe_act", n_pea, 4);
    chk_int("frm_ne_act", n_nea, 4);

    // 5: sclk outside a frame
    clr_counts();
    sclk_periods(2);
    negs(4);
    chk_int("nf_pe", n_pe, 2);
    chk_int("nf_ne", n_ne, 2);
    chk_int("nf_pe_act", n_pea, 0);
    chk_int("nf_ne_act", n_nea, 0);

    // 6: reset mid-frame
    clr_counts();
    cs_pin = 1'b0;
    negs(10);
    chk("rst_pre_cs", cs_cond, 1'b0);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("rst_cs", cs_cond, 1'b1);
    chk("rst_fe", frame_end, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    negs(10);
    chk_int("rst_no_fe", n_fe, 0);
    chk_int("rst_fs_again", n_fs, 2);
    chk("rst_cs_again", cs_cond, 1'b0);
    cs_pin = 1'b1;
    negs(10);

    // random pins with short holds and occasional reset
    for (int c = 0; c < 3; c++) hold[c] = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          hold[c] = $urandom_range(1, 9);
          case (c)
            0: sclk_pin = 1'($urandom_range(0, 1));
            1: cs_pin = 1'($urandom_range(0, 1));
            default: mosi_pin = 1'($urandom_range(0, 1));
          endcase
        end
        hold[c]--;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    sclk_pin = 1'b0;
    cs_pin = 1'b1;
    mosi_pin = 1'b0;
    negs(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
